// File: rtl/fifo_rtl_pkg.sv
// Shared types and helpers for the FIFO read-side controller and its output buffer.
package fifo_rtl_pkg;

  localparam int unsigned FIFO_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH
  } rd_state_e;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Small circular output buffer: push at tail, pop at head, synchronous clear.
module fifo_rd_skid_buf
  import fifo_rtl_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int unsigned DEPTH = 3,
  localparam int unsigned OW   = occ_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [OW-1:0]    occ_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]    occ_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i && (occ_q != '0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && ((occ_q != OW'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO consumer: credit-limited reads into a small buffer, valid/ready output, flush.
// Optional saturating statistics counters are enabled by defining FIFO_RD_CTRL_STATS_EN.
module fifo_rd_ctrl
  import fifo_rtl_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int unsigned BUF_DEPTH  = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  flush_done,
  output logic                  underflow_err,
  output logic [CNT_W-1:0]      words_out,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int unsigned OW = occ_width(BUF_DEPTH);

  rd_state_e       state_q;
  logic            pending_q;
  logic            flush_done_q;
  logic            underflow_err_q;
  logic [OW-1:0]   occ;
  logic [FIFO_WIDTH-1:0] head;
  logic            credit_ok;
  logic            xfer;
  logic            buf_push;
  logic            buf_clear;

  // Words already buffered plus the one in flight must leave room for another.
  assign credit_ok = ({1'b0, occ} + {{OW{1'b0}}, pending_q}) < (OW + 1)'(BUF_DEPTH);

  always_comb begin
    fifo_rd_en = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ACTIVE:  fifo_rd_en = !fifo_empty && credit_ok;
        FLUSH:   fifo_rd_en = !fifo_empty;
        default: fifo_rd_en = 1'b0;
      endcase
    end
  end

  assign m_valid   = (occ != '0) && (state_q != FLUSH);
  assign xfer      = m_valid && m_ready;
  assign buf_push  = pending_q && (state_q == ACTIVE);
  assign buf_clear = ((state_q == ACTIVE) && flush) || (state_q == FLUSH);

  fifo_rd_skid_buf #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (buf_push),
    .push_data_i (fifo_data_out),
    .pop_i       (xfer),
    .clear_i     (buf_clear),
    .occ_o       (occ),
    .head_o      (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      pending_q       <= 1'b0;
      flush_done_q    <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      pending_q    <= fifo_rd_en;
      flush_done_q <= 1'b0;
      if (fifo_underflow) begin
        underflow_err_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (flush) begin
            flush_done_q <= 1'b1;
          end else if (!fifo_empty) begin
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (flush) begin
            state_q <= FLUSH;
          end else if (fifo_empty && (occ == '0) && !pending_q) begin
            state_q <= IDLE;
          end
        end
        FLUSH: begin
          if (fifo_empty && !pending_q) begin
            flush_done_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_data        = head;
  assign busy          = (state_q != IDLE);
  assign flush_done    = flush_done_q;
  assign underflow_err = underflow_err_q;

`ifdef FIFO_RD_CTRL_STATS_EN
  logic [CNT_W-1:0] words_q;
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (xfer && (words_q != '1)) begin
        words_q <= words_q + CNT_W'(1);
      end
      if (m_valid && !m_ready && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign words_out    = words_q;
  assign stall_cycles = stall_q;
`else
  assign words_out    = '0;
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: queue-based FIFO model and in-order scoreboard, directed + random steps.
module tb_fifo_rd_ctrl;

  localparam int W  = 16;
  localparam int D  = 3;
  localparam int CW = 16;
`ifdef FIFO_RD_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, fifo_rd_en, fifo_empty, fifo_underflow, flush;
  logic          m_valid, m_ready, busy, flush_done, underflow_err;
  logic [W-1:0]  fifo_data_out, m_data;
  logic [CW-1:0] words_out, stall_cycles;

  always #5 clk = ~clk;

  fifo_rd_ctrl #(
    .FIFO_WIDTH (W),
    .BUF_DEPTH  (D),
    .CNT_W      (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_data_out  (fifo_data_out),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .flush          (flush),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_ready        (m_ready),
    .busy           (busy),
    .flush_done     (flush_done),
    .underflow_err  (underflow_err),
    .words_out      (words_out),
    .stall_cycles   (stall_cycles)
  );

  logic [W-1:0] fq[$];     // words still inside the modelled FIFO
  logic [W-1:0] exp_q[$];  // words read from the FIFO, not yet delivered
  int           total = 0;
  int           bad   = 0;
  int           n_xfer = 0, n_stall = 0, n_fdone = 0;
  int           cyc = 0, first_v = -1;
  logic [31:0]  rd_hist = '0, v_hist = '0;
  bit           hold_v = 1'b0, flushing = 1'b0;
  logic [W-1:0] hold_d = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample/check at the falling edge, then model the FIFO just after the rising edge.
  task automatic tick();
    bit rd_s, rst_s;
    @(negedge clk);
    if (hold_v) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", 32'(m_data), 32'(hold_d));
    end
    if (m_valid && m_ready) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("order", 32'(m_data), 32'(exp_q.pop_front()));
      n_xfer++;
    end
    if (m_valid && !m_ready) n_stall++;
    if (!flushing && !rst) chk("credit", 32'(exp_q.size() <= D), 32'd1);
    if (flush_done) begin
      n_fdone++;
      exp_q.delete();
    end
    hold_v = m_valid && !m_ready && !flush && !rst;
    hold_d = m_data;
    rd_s   = fifo_rd_en;
    rst_s  = rst;
    if (cyc < 32) begin
      rd_hist[cyc] = fifo_rd_en;
      v_hist[cyc]  = m_valid;
    end
    if (m_valid === 1'b1 && first_v < 0) first_v = cyc;
    cyc++;
    if (rd_s) chk("no_overread", 32'(fq.size() != 0), 32'd1);
    @(posedge clk);
    #1;
    if (rst_s) begin
      exp_q.delete();
      n_xfer  = 0;
      n_stall = 0;
      hold_v  = 1'b0;
    end else if (rd_s && fq.size() != 0) begin
      fifo_data_out = fq.pop_front();
      exp_q.push_back(fifo_data_out);
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic load(input int n, input int base, input bit rnd);
    for (int i = 0; i < n; i++) fq.push_back(rnd ? W'($urandom) : W'(base + i));
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic mark();
    cyc = 0; first_v = -1; rd_hist = '0; v_hist = '0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    m_ready = 1'b1;
    #1;
    while ((exp_q.size() != 0 || fq.size() != 0 || busy) && n < 100) begin
      tick(); #1; n++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size() + fq.size()), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_data"}, 32'(m_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_fdone"}, 32'(flush_done), 32'd0);
    chk({tag, "_uerr"}, 32'(underflow_err), 32'd0);
    chk({tag, "_words"}, 32'(words_out), 32'd0);
    chk({tag, "_stall"}, 32'(stall_cycles), 32'd0);
    chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wsave;
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0; fifo_underflow = 1'b0;
    fifo_empty = 1'b1; fifo_data_out = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk_zero("reset");

    // Five preloaded words, always ready: back-to-back reads, two-cycle latency.
    mark();
    m_ready = 1'b1;
    load(5, 1, 1'b0);
    repeat (12) tick();
    #1;
    chk("t1_first_rd", 32'(rd_hist[1]), 32'd1);
    chk("t1_rd_run", rd_hist, 32'h1F << 1);
    chk("t1_first_valid", 32'(first_v), 32'd3);
    chk("t1_valid_run", v_hist, 32'h1F << 3);
    chk("t1_words", 32'(words_out), STATS ? 32'(n_xfer) : 32'd0);
    chk("t1_xfers", 32'(n_xfer), 32'd5);
    chk("t1_idle", 32'(busy), 32'd0);

    // Eight words, downstream stalled: only BUF_DEPTH reads, head held.
    mark();
    m_ready = 1'b0;
    load(8, 1, 1'b0);
    repeat (10) tick();
    #1;
    chk("t2_reads", 32'($countones(rd_hist)), 32'(D));
    chk("t2_valid", 32'(m_valid), 32'd1);
    chk("t2_head", 32'(m_data), 32'h0001);
    chk("t2_stall", 32'(stall_cycles), STATS ? 32'(n_stall) : 32'd0);
    wsave = n_xfer;
    drain("t2");
    chk("t2_delivered", 32'(n_xfer - wsave), 32'd8);

    // Alternating ready with 20 random words exercises pointer wrap-around.
    load(20, 0, 1'b1);
    for (int i = 0; i < 60; i++) begin
      m_ready = i[0];
      tick();
    end
    drain("t3");

    // Random ready pattern.
    load(30, 0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain("t3r");
    chk("t3_words", 32'(words_out), STATS ? 32'(n_xfer) : 32'd0);

    // Flush with two buffered words and four more in the FIFO.
    m_ready = 1'b0;
    load(2, 'h100, 1'b0);
    repeat (5) tick();
    wsave = n_xfer;
    n_fdone = 0;
    load(4, 'h200, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    flushing = 1'b1;
    #1;
    chk("t4_valid_off", 32'(m_valid), 32'd0);
    repeat (15) tick();
    #1;
    flushing = 1'b0;
    chk("t4_fdone_count", 32'(n_fdone), 32'd1);
    chk("t4_fifo_empty", 32'(fq.size()), 32'd0);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_xfers", 32'(n_xfer), 32'(wsave));
    chk("t4_words", 32'(words_out), STATS ? 32'(wsave) : 32'd0);

    // Flush while idle: one-cycle pulse on the following cycle.
    n_fdone = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("t4i_pulse", 32'(flush_done), 32'd1);
    tick();
    #1;
    chk("t4i_pulse_end", 32'(flush_done), 32'd0);
    chk("t4i_count", 32'(n_fdone), 32'd1);

    // Reset with two buffered words and one read in flight.
    m_ready = 1'b0;
    load(2, 'h300, 1'b0);
    repeat (5) tick();
    load(3, 'h400, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("t5_rd_in_rst", 32'(fifo_rd_en), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk_zero("t5_after_rst");
    chk("t5_fifo_left", 32'(fq.size()), 32'd2);
    mark();
    drain("t5");
    chk("t5_xfers", 32'(n_xfer), 32'd2);
    chk("t5_words", 32'(words_out), STATS ? 32'd2 : 32'd0);

    // Underflow is sticky until reset.
    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    #1;
    chk("t6_set", 32'(underflow_err), 32'd1);
    repeat (5) tick();
    #1;
    chk("t6_sticky", 32'(underflow_err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_cleared", 32'(underflow_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
